// File: rtl/sme_unmask.sv
// Sequential unmasking of an SME-shared operand: folds one share per cycle
// into an accumulator using XOR (boolean) or modular addition (arithmetic).
module sme_unmask #(
  parameter int XLEN = 32,
  parameter int SMAX = 4
) (
  input  logic                      g_clk,
  input  logic                      g_reset,
  input  logic                      flush,
  input  logic                      valid,
  output logic                      ready,
  input  logic                      smectl_t,
  input  logic [3:0]                smectl_d,
  input  logic [SMAX-1:0][XLEN-1:0] rs1,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [XLEN-1:0]           rd
);

  localparam int SM = SMAX - 1;
  localparam int XL = XLEN - 1;
  localparam int CW = $clog2(SMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [SM:0][XL:0]  r_shares;
  logic [XL:0]        r_acc;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_d;
  logic               r_smeT;
  logic               r_ready;
  logic               r_rdValid;

  logic [CW-1:0]      w_dEff;
  logic [CW-1:0]      w_cntNext;
  logic [XL:0]        w_share;
  logic [XL:0]        w_fold;

  // Share count in use: zero means a single share, anything past SMAX saturates.
  always_comb begin
    w_dEff = CW'(smectl_d);
    if (smectl_d == 4'd0) begin
      w_dEff = CW'(1);
    end else if (32'(smectl_d) > SMAX) begin
      w_dEff = CW'(SMAX);
    end
  end

  always_comb begin
    w_share = '0;
    for (int i = 0; i < SMAX; i++) begin
      if (r_cnt == CW'(i)) begin
        w_share = r_shares[i];
      end
    end
  end

  assign w_cntNext = r_cnt + CW'(1);
  assign w_fold    = r_smeT ? (r_acc + w_share) : (r_acc ^ w_share);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state   <= IDLE;
      r_shares  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_smeT    <= 1'b0;
      r_ready   <= 1'b1;
      r_rdValid <= 1'b0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_shares  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_smeT    <= 1'b0;
      r_ready   <= 1'b1;
      r_rdValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_shares <= rs1;
            r_smeT   <= smectl_t;
            r_d      <= w_dEff;
            r_acc    <= rs1[0];
            r_cnt    <= CW'(1);
            r_ready  <= 1'b0;
            if (w_dEff >= CW'(2)) begin
              r_state <= FOLD;
            end else begin
              r_state   <= DONE;
              r_rdValid <= 1'b1;
            end
          end
        end
        FOLD: begin
          r_acc <= w_fold;
          r_cnt <= w_cntNext;
          if (w_cntNext == r_d) begin
            r_state   <= DONE;
            r_rdValid <= 1'b1;
          end
        end
        DONE: begin
          // Result leaves only on handshake; key material is wiped on the way out.
          if (rd_ready) begin
            r_state   <= IDLE;
            r_shares  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_rdValid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ready   <= 1'b1;
          r_rdValid <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign rd_valid = r_rdValid;
  assign rd       = r_rdValid ? r_acc : '0;

endmodule

// File: tb/tb_sme_unmask.sv
// Randomised and directed self-checking bench for sme_unmask against a
// share-folding reference model.
module tb_sme_unmask;

  logic             g_clk;
  logic             g_reset;
  logic             flush;
  logic             valid;
  logic             ready;
  logic             smectl_t;
  logic [3:0]       smectl_d;
  logic [3:0][31:0] rs1;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd;

  int errors;
  int checks;

  sme_unmask dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .flush    (flush),
    .valid    (valid),
    .ready    (ready),
    .smectl_t (smectl_t),
    .smectl_d (smectl_d),
    .rs1      (rs1),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd       (rd)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int effD(input logic [3:0] d);
    if (d == 0) return 1;
    if (d > 4) return 4;
    return int'(d);
  endfunction

  // Reference: sum or XOR-reduce the first D shares.
  function automatic logic [31:0] unmask(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < effD(d); i++) begin
      if (t) acc = acc + sh[i];
      else   acc = acc ^ sh[i];
    end
    return acc;
  endfunction

  task automatic startOp(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh);
    @(negedge g_clk);
    checkOutput("readyBeforeAccept", {31'b0, ready}, 32'h1);
    valid    = 1'b1;
    smectl_t = t;
    smectl_d = d;
    rs1      = sh;
    @(posedge g_clk);
    #1;
    valid    = 1'b0;
    smectl_t = 1'($urandom);
    smectl_d = 4'($urandom);
    rs1      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic applyStimulus(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh, input int hold);
    logic [31:0] expRd;
    int lat;
    expRd = unmask(t, d, sh);
    lat = 0;
    startOp(t, d, sh);
    for (int n = 1; n <= 20; n++) begin
      @(negedge g_clk);
      if (rd_valid) begin
        lat = n;
        break;
      end
      checkOutput("rdHiddenWhileFolding", rd, 32'h0);
    end
    checkOutput("latency", 32'(lat), 32'(effD(d)));
    checkOutput("rd", rd, expRd);
    for (int k = 0; k < hold; k++) begin
      valid = 1'b1;
      rs1   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge g_clk);
      checkOutput("rdHeld", rd, expRd);
      checkOutput("rdValidHeld", {31'b0, rd_valid}, 32'h1);
      checkOutput("readyLowInDone", {31'b0, ready}, 32'h0);
    end
    valid    = 1'b0;
    rd_ready = 1'b1;
    @(posedge g_clk);
    #1;
    rd_ready = 1'b0;
    checkOutput("readyAfterHandshake", {31'b0, ready}, 32'h1);
    checkOutput("rdValidAfterHandshake", {31'b0, rd_valid}, 32'h0);
    checkOutput("rdZeroAfterHandshake", rd, 32'h0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    g_reset  = 1'b1;
    flush    = 1'b0;
    valid    = 1'b0;
    smectl_t = 1'b0;
    smectl_d = 4'd0;
    rs1      = '0;
    rd_ready = 1'b0;
    #12;
    checkOutput("resetReady", {31'b0, ready}, 32'h1);
    checkOutput("resetRdValid", {31'b0, rd_valid}, 32'h0);
    checkOutput("resetRd", rd, 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;

    // Directed vectors
    applyStimulus(1'b0, 4'd3, {32'hDEADBEEF, 32'h4, 32'h2, 32'h1}, 2);
    applyStimulus(1'b1, 4'd4, {32'h5, 32'h10, 32'h1, 32'hFFFFFFFF}, 0);
    applyStimulus(1'b1, 4'd0, {32'h1, 32'h1, 32'h1, 32'h12345678}, 0);
    applyStimulus(1'b1, 4'd9, {32'h1, 32'h1, 32'h1, 32'h12345678}, 0);
    applyStimulus(1'b0, 4'd2, {32'h0, 32'h0, 32'hFFFF0000, 32'h0000FFFF}, 5);

    // Flush on the second FOLD cycle discards the operation
    startOp(1'b1, 4'd4, {32'h4, 32'h3, 32'h2, 32'h1});
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    valid = 1'b1;
    rd_ready = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    rd_ready = 1'b0;
    checkOutput("flushReady", {31'b0, ready}, 32'h1);
    checkOutput("flushRdValid", {31'b0, rd_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      checkOutput("noResultAfterFlush", {31'b0, rd_valid}, 32'h0);
    end
    applyStimulus(1'b0, 4'd1, {32'h0, 32'h0, 32'h0, 32'hA5}, 0);

    // Asynchronous reset mid-FOLD
    startOp(1'b0, 4'd4, {32'h8, 32'h7, 32'h6, 32'h5});
    @(negedge g_clk);
    #2;
    g_reset = 1'b1;
    #1;
    checkOutput("asyncResetRdValid", {31'b0, rd_valid}, 32'h0);
    checkOutput("asyncResetReady", {31'b0, ready}, 32'h1);
    checkOutput("asyncResetRd", rd, 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge g_clk);
      checkOutput("noStaleAfterReset", {31'b0, rd_valid}, 32'h0);
    end

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      logic [3:0][31:0] sh;
      sh = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) sh[$urandom_range(0, 3)] = 32'hFFFFFFFF;
      applyStimulus(1'($urandom), 4'($urandom), sh, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sme_unmask.md
SME_UNMASK -- requirements
Module: sme_unmask

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the width of each share and of the result.
REQ-002 The parameter SMAX SHALL default to 4 and set the maximum number of hardware shares; SM=SMAX-1, XL=XLEN-1.
REQ-003 The port g_clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on the rising edge.
REQ-004 The port g_reset SHALL be an input, 1 bit wide, and be the reset; it is asynchronous and active-high.
REQ-005 The port flush SHALL be an input, 1 bit wide, and abandon the current operation and discard its result.
REQ-006 The port valid SHALL be an input, 1 bit wide, and indicate that the input shares are presented.
REQ-007 The port ready SHALL be an output, 1 bit wide, and indicate that the block can accept input.
REQ-008 The port smectl_t SHALL be an input, 1 bit wide, and select the masking type: 0=boolean (XOR), 1=arithmetic (add mod 2^XLEN).
REQ-009 The port smectl_d SHALL be an input, 4 bits wide, and give the number of shares in use.
REQ-010 The port rs1 SHALL be an input of SMAX shares, each XLEN bits wide, holding the masked operand.
REQ-011 The port rd_valid SHALL be an output, 1 bit wide, and indicate that the unmasked result is available.
REQ-012 The port rd_ready SHALL be an input, 1 bit wide, and indicate that the consumer accepts the result.
REQ-013 The port rd SHALL be an output, XLEN bits wide, and carry the unmasked result.

Function
REQ-014 The block SHALL implement the inverse of the SME mask operation by sequentially folding shares, one share per cycle, into an accumulator.
REQ-015 The FSM SHALL have three states: IDLE, FOLD and DONE.
REQ-016 ready SHALL equal 1 only in IDLE; an input is accepted on a rising edge where valid=1, ready=1 and flush=0.
REQ-017 On acceptance, the block SHALL latch all SMAX shares, smectl_t and the effective share count D, and set acc=rs1[0] and cnt=1.
REQ-018 D SHALL equal 1 when smectl_d=0, SMAX when smectl_d>SMAX, and smectl_d otherwise.
REQ-019 After acceptance, the next state SHALL be FOLD if D>=2, else DONE.
REQ-020 In FOLD, each cycle SHALL set acc=acc XOR share[cnt] (bool) or acc=acc+share[cnt] mod 2^XLEN (arith), and increment cnt.
REQ-021 When the incremented cnt equals D, FOLD SHALL transition to DONE.
REQ-022 Latency: rd_valid SHALL rise exactly D cycles after the accepting edge.
REQ-023 In DONE, rd_valid=1 and rd=acc SHALL be held stable until the edge where rd_ready=1; the block then returns to IDLE.
REQ-024 rd SHALL be all-zero whenever rd_valid=0, so partial sums are never exposed.
REQ-025 The share registers and acc SHALL be zeroised on the DONE->IDLE handshake edge.
REQ-026 valid SHALL be ignored outside IDLE, and inputs SHALL be sampled only on the accepting edge.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge, zeroise the shares, acc and cnt, and drop rd_valid without a handshake.
REQ-028 flush SHALL take priority over valid and rd_ready in the same cycle, so no acceptance occurs.
REQ-029 smectl_t and smectl_d changes after acceptance SHALL have no effect on the in-flight operation.

Reset
REQ-030 While g_reset=1, asynchronously: state=IDLE, cnt=0, shares=0, acc=0, rd_valid=0, rd=0 and ready=1.
REQ-031 Reset asserted mid-FOLD or mid-DONE SHALL abandon the operation; after release, no rd_valid SHALL occur until a new acceptance.

Verification
REQ-032 Bool, d=3, shares 0x00000001/0x00000002/0x00000004/0xDEADBEEF -> rd_valid 3 cycles after accept, rd=0x00000007, share3 ignored.
REQ-033 Arith, d=4, shares 0xFFFFFFFF/0x00000001/0x00000010/0x00000005 -> rd=0x00000015 (wrap), rd_valid 4 cycles after accept.
REQ-034 Arith, d=0 then d=9, share0=0x12345678, others 0x1 -> rd=0x12345678 at 1 cycle (d=0); rd=0x1234567B at 4 cycles (d=9 clamped).
REQ-035 Flush on the 2nd FOLD cycle, d=4 -> no rd_valid, ready=1 next cycle, a following bool d=1 op with share0=0xA5 yields rd=0xA5.
REQ-036 rd_ready held 0 for 5 cycles in DONE with valid=1 and changing rs1 -> rd stable, ready=0, no acceptance; rd_ready=1 -> IDLE next cycle, rd=0.
REQ-037 g_reset pulsed mid-FOLD (asynchronous, between edges) -> rd_valid=0 immediately, ready=1, and no stale result after release.
